// File: rtl/vga_frame_reader.sv
// VGA scan-out from the gray frame RAM, with sync/blank/pixel aligned to the RAM read latency.
// Optional `TEST_PATTERN_EN adds tp_sel and a checker+ramp pattern for in-window pixels.
module vga_frame_reader #(
  parameter int         H_VIS  = 640,
  parameter int         H_FP   = 16,
  parameter int         H_SYNC = 96,
  parameter int         H_BP   = 48,
  parameter int         V_VIS  = 480,
  parameter int         V_FP   = 10,
  parameter int         V_SYNC = 2,
  parameter int         V_BP   = 33,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] BORDER = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw,
  input  logic        frame_ready,
`ifdef TEST_PATTERN_EN
  input  logic        tp_sel,
`endif
  output logic [18:0] ram_addr,
  input  logic [7:0]  ram_data,
  output logic [7:0]  pixel_out,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_VIS + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG  = V_VIS + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC - 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vid;
    logic       fs;
    logic       win;
    logic       arm;
`ifdef TEST_PATTERN_EN
    logic       tp;
    logic [7:0] pat;
`endif
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, default: '0};

  logic [9:0]  h_cnt, v_cnt;
  logic        h_wrap, v_wrap, at00;
  logic        scale_q, armed_q, seen_q;
  logic        scale_eff, arm_eff;
  logic [10:0] x0, y0, img_w, img_h, dh, dv;
  logic        in_win;
  logic [18:0] row_base;
  ctrl_t       ctrl_d;
  ctrl_t [RD_LAT:0] ctrl_pipe;
  ctrl_t       o;

  assign h_wrap = (h_cnt == 10'(H_TOTAL - 1));
  assign v_wrap = (v_cnt == 10'(V_TOTAL - 1));
  assign at00   = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Scale and arming take effect at (0,0) using the inputs seen on that very cycle.
  assign scale_eff = at00 ? sw : scale_q;
  assign arm_eff   = armed_q | (at00 & (seen_q | frame_ready));

  always_ff @(posedge clk) begin
    if (!rst) begin
      scale_q <= 1'b1;
      armed_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      seen_q <= seen_q | frame_ready;
      if (at00) begin
        scale_q <= sw;
        if (seen_q | frame_ready) armed_q <= 1'b1;
      end
    end
  end

  assign x0    = scale_eff ? 11'd0 : 11'(H_VIS / 4);
  assign y0    = scale_eff ? 11'd0 : 11'(V_VIS / 4);
  assign img_w = scale_eff ? 11'(H_VIS) : 11'(H_VIS / 2);
  assign img_h = scale_eff ? 11'(V_VIS) : 11'(V_VIS / 2);
  // Rows/columns before the origin wrap to large values and fall out of the window.
  assign dh     = {1'b0, h_cnt} - x0;
  assign dv     = {1'b0, v_cnt} - y0;
  assign in_win = (dh < img_w) && (dv < img_h);

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_base <= '0;
      ram_addr <= '0;
    end else begin
      if (h_wrap) begin
        if (v_wrap)          row_base <= '0;
        else if (dv < img_h) row_base <= row_base + 19'(img_w);
      end
      if (in_win) ram_addr <= row_base + 19'(dh);
    end
  end

  always_comb begin
    ctrl_d     = CTRL_IDLE;
    ctrl_d.hs  = !((h_cnt >= 10'(HS_BEG)) && (h_cnt <= 10'(HS_END)));
    ctrl_d.vs  = !((v_cnt >= 10'(VS_BEG)) && (v_cnt <= 10'(VS_END)));
    ctrl_d.vid = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
    ctrl_d.fs  = at00;
    ctrl_d.win = in_win;
    ctrl_d.arm = arm_eff;
`ifdef TEST_PATTERN_EN
    ctrl_d.tp  = tp_sel | ~arm_eff;
    ctrl_d.pat = {h_cnt[5] ^ v_cnt[5], 7'h00} | (h_cnt[7:0] & 8'h7F);
`endif
  end

  // Stage 0 is registered alongside ram_addr; the last stage meets ram_data.
  always_ff @(posedge clk) begin
    if (!rst) ctrl_pipe <= {(RD_LAT + 1){CTRL_IDLE}};
    else      ctrl_pipe <= {ctrl_pipe[RD_LAT-1:0], ctrl_d};
  end

  assign o           = ctrl_pipe[RD_LAT];
  assign hsync       = o.hs;
  assign vsync       = o.vs;
  assign video_on    = o.vid;
  assign frame_start = o.fs;

  always_comb begin
    pixel_out = 8'h00;
    if (!o.vid)      pixel_out = 8'h00;
`ifdef TEST_PATTERN_EN
    else if (o.win && o.tp) pixel_out = o.pat;
`endif
    else if (!o.arm) pixel_out = 8'h00;
    else if (!o.win) pixel_out = BORDER;
    else             pixel_out = ram_data;
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench on a shrunken 24x18 raster (16x12 visible) so several frames run quickly.
module tb_vga_frame_reader;
  localparam int HT = 24;
  localparam int FT = 24 * 18;

  logic        clk = 1'b0;
  logic        rst, sw, frame_ready;
  logic [18:0] ram_addr;
  logic [7:0]  ram_data, pixel_out;
  logic        hsync, vsync, video_on, frame_start;
`ifdef TEST_PATTERN_EN
  logic        tp_sel = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .RD_LAT(1), .BORDER(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .frame_ready(frame_ready),
`ifdef TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .ram_addr(ram_addr), .ram_data(ram_data), .pixel_out(pixel_out),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start)
  );

  // One-cycle RAM; contents scrambled so address 0 differs from BORDER.
  always @(posedge clk) ram_data <= ram_addr[7:0] ^ 8'hA5;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to the negedge where counter position (h,v) of frame f shows up after lag cycles.
  task automatic at_pix(input int f, input int h, input int v, input int lag);
    int tgt;
    tgt = f * FT + v * HT + h + lag;
    if (tgt < cyc) chk("order", cyc, tgt);
    while (cyc < tgt) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b0; sw = 1'b1; frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_vid",   video_on, 0);
    chk("rst_fs",    frame_start, 0);
    chk("rst_pix",   pixel_out, 0);
    chk("rst_addr",  ram_addr, 0);

    // frame_ready high on the (0,0) cycle arms frame 0 immediately
    frame_ready = 1'b1; rst = 1'b1; cyc = 0;
    at_pix(0, 0, 0, 1);  chk("fs_pre", frame_start, 0);
    at_pix(0, 0, 0, 2);  chk("fs0", frame_start, 1);
    chk("pix00", pixel_out, 8'hA5);
    chk("vid00", video_on, 1);
    frame_ready = 1'b0;
    at_pix(0, 1, 0, 2);  chk("fs_post", frame_start, 0);
    at_pix(0, 15, 0, 2); chk("vid15", video_on, 1);
    at_pix(0, 16, 0, 2); chk("vid16", video_on, 0);
    chk("pix16", pixel_out, 0);
    at_pix(0, 5, 1, 1);  chk("addr51", ram_addr, 21);
    at_pix(0, 5, 1, 2);  chk("pix51", pixel_out, 8'hB0);
    at_pix(0, 20, 1, 1); chk("addr_hold", ram_addr, 31);
    at_pix(0, 17, 2, 2); chk("hs17", hsync, 1);
    at_pix(0, 18, 2, 2); chk("hs18", hsync, 0);
    at_pix(0, 20, 2, 2); chk("hs20", hsync, 0);
    at_pix(0, 21, 2, 2); chk("hs21", hsync, 1);
    at_pix(0, 0, 6, 0);  sw = 1'b0;
    at_pix(0, 15, 11, 2); chk("pix_last", pixel_out, 8'h1A);
    at_pix(0, 23, 13, 2); chk("vs13", vsync, 1);
    at_pix(0, 0, 14, 2);  chk("vs14", vsync, 0);
    at_pix(0, 23, 15, 2); chk("vs15", vsync, 0);
    at_pix(0, 0, 16, 2);  chk("vs16", vsync, 1);

    // frame 1: half-size image centred at (4,3)
    at_pix(1, 0, 0, 2);  chk("fs1", frame_start, 1);
    chk("pix1_00", pixel_out, 0);
    at_pix(1, 3, 3, 2);  chk("border_l", pixel_out, 0);
    chk("border_vid", video_on, 1);
    at_pix(1, 4, 3, 2);  chk("win_first", pixel_out, 8'hA5);
    at_pix(1, 11, 8, 1); chk("addr_max", ram_addr, 47);
    at_pix(1, 11, 8, 2); chk("win_last", pixel_out, 8'h8A);
    at_pix(1, 12, 8, 2); chk("border_r", pixel_out, 0);

    // one-cycle reset mid-frame
    sw = 1'b1;
    at_pix(2, 10, 5, 0); rst = 1'b0;
    @(negedge clk);
    chk("mrst_hsync", hsync, 1);
    chk("mrst_vid",   video_on, 0);
    chk("mrst_fs",    frame_start, 0);
    chk("mrst_pix",   pixel_out, 0);
    chk("mrst_addr",  ram_addr, 0);
    rst = 1'b1; cyc = 0;
    at_pix(0, 0, 0, 2);  chk("fs_r0", frame_start, 1);
    at_pix(0, 5, 1, 2);  chk("unarmed", pixel_out, 0);
    chk("unarmed_vid", video_on, 1);
    at_pix(0, 0, 3, 0);  frame_ready = 1'b1;
    at_pix(0, 1, 3, 0);  frame_ready = 1'b0;
    at_pix(0, 5, 5, 2);  chk("arm_wait", pixel_out, 0);
    at_pix(1, 0, 0, 1);  chk("fs_r1_pre", frame_start, 0);
    at_pix(1, 0, 0, 2);  chk("fs_r1", frame_start, 1);
    at_pix(1, 5, 1, 2);  chk("rearmed", pixel_out, 8'hB0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
